// File: rtl/pdp8_iot_pkg.sv
// Shared PDP-8 IOT definitions: device codes, keyboard opcodes and the machine word type.
// Helper functions classify keyboard opcodes so decode stays in one place.
package pdp8_iot_pkg;

    typedef logic [11:0] word_t;

    localparam logic [5:0] KBD_DEV = 6'o03;
    localparam logic [5:0] TTY_DEV = 6'o04;

    typedef enum logic [2:0] {
        KCF     = 3'd0,
        KSF     = 3'd1,
        KCC     = 3'd2,
        KNOP    = 3'd3,
        KRS     = 3'd4,
        KIE     = 3'd5,
        KRB     = 3'd6,
        KRB_ALT = 3'd7
    } kbd_op_e;

    // Operations that consume the head character (when the flag is up).
    function automatic logic kbd_pops(input kbd_op_e op);
        return (op == KCF) || (op == KCC) || (op == KRB) || (op == KRB_ALT);
    endfunction

    function automatic logic kbd_clears_ac(input kbd_op_e op);
        return (op == KCC) || (op == KRB) || (op == KRB_ALT);
    endfunction

    function automatic logic kbd_reads(input kbd_op_e op);
        return (op == KRS) || (op == KRB) || (op == KRB_ALT);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Small single-clock FIFO with asynchronous reset and combinational head read.
// Push while full and pop while empty are ignored; full/empty reflect registered state only.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [AW:0]      count_reg, count_next;
    logic             push_ok, pop_ok;

    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (push_ok) begin
            wr_ptr_next = wr_ptr_reg + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_next = rd_ptr_reg + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset: contents are meaningless once the pointers are cleared.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == AW'(gi))) begin
                    mem[gi] <= wr_data;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/kl8e_keyboard.sv
// KL8E console keyboard: buffers UART characters and serves them to the CPU via IOTs.
// IOT outputs are combinational in the strobe cycle; state changes land on the next edge.
module kl8e_keyboard
    import pdp8_iot_pkg::*;
#(
    parameter logic [5:0] DEVICE = KBD_DEV,
    parameter int         DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_load,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic        iot,
    input  logic [5:0]  iot_dev,
    input  logic [2:0]  iot_op,
    input  logic [11:0] ac_in,
    output logic        skip,
    output logic        ac_clear,
    output logic [11:0] ac_out,
    output logic        irq,
    output logic        overrun
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          selected;
    logic          flag;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic [7:0]    head;
    logic [CW-1:0] fifo_count;
    kbd_op_e       op;
    word_t         ac_out_next;
    logic          int_enable_reg, int_enable_next;
    logic          overrun_reg, overrun_next;
    logic          unused_ac_bits;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (rx_load),
        .pop     (pop),
        .wr_data (rx_data),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Gating with rst keeps every IOT response quiet while reset is held.
    assign selected       = iot && (iot_dev == DEVICE) && !rst;
    assign op             = kbd_op_e'(iot_op);
    assign flag           = !fifo_empty;
    assign rx_ready       = (fifo_count != CW'(DEPTH));
    assign irq            = flag && int_enable_reg;
    assign overrun        = overrun_reg;
    assign ac_out         = ac_out_next;
    assign unused_ac_bits = ^ac_in[11:1];

    always_comb begin
        skip            = 1'b0;
        ac_clear        = 1'b0;
        ac_out_next     = '0;
        pop             = 1'b0;
        int_enable_next = int_enable_reg;
        if (selected) begin
            skip     = (op == KSF) && flag;
            ac_clear = kbd_clears_ac(op);
            pop      = kbd_pops(op) && flag;
            if (kbd_reads(op) && flag) begin
                ac_out_next = {4'b0000, head};
            end
            if (op == KIE) begin
                int_enable_next = ac_in[0];
            end
        end
    end

    // A drop in the same cycle as a clearing IOT leaves overrun set.
    always_comb begin
        overrun_next = overrun_reg;
        if (selected && iot_op[1]) begin
            overrun_next = 1'b0;
        end
        if (rx_load && fifo_full) begin
            overrun_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            int_enable_reg <= 1'b1;
            overrun_reg    <= 1'b0;
        end else begin
            int_enable_reg <= int_enable_next;
            overrun_reg    <= overrun_next;
        end
    end

endmodule
